// File: rtl/keypad_input_unit_if.sv
// Keypad-to-core bus: debounced key level/code in, operand/operator/status out.
//   IN_key_down, IN_key_code     : scanner -> keypad unit
//   OUT_SRCH/L, OUT_DSTH/L       : first/second operand bytes
//   OUT_ALU_OP, OUT_finish       : latched operator, one-cycle complete pulse
//   OUT_state, OUT_flag          : entry phase and digits typed in current operand
interface keypad_input_unit_if;
  logic       IN_key_down;
  logic [3:0] IN_key_code;
  logic [7:0] OUT_SRCH;
  logic [7:0] OUT_SRCL;
  logic [7:0] OUT_DSTH;
  logic [7:0] OUT_DSTL;
  logic [3:0] OUT_ALU_OP;
  logic       OUT_finish;
  logic [1:0] OUT_state;
  logic [1:0] OUT_flag;

  // Keypad unit side
  modport master (
    input  IN_key_down, IN_key_code,
    output OUT_SRCH, OUT_SRCL, OUT_DSTH, OUT_DSTL,
           OUT_ALU_OP, OUT_finish, OUT_state, OUT_flag
  );

  // Scanner/core side
  modport slave (
    output IN_key_down, IN_key_code,
    input  OUT_SRCH, OUT_SRCL, OUT_DSTH, OUT_DSTL,
           OUT_ALU_OP, OUT_finish, OUT_state, OUT_flag
  );
endinterface

// File: rtl/keypad_input_unit.sv
// Keypad input unit: accumulates decimal key digits into 16-bit operands,
// latches the operator and pulses finish on '=' after the second operand.
// Ports:
//   IN_clk : system clock
//   IN_rst : synchronous active-high reset
//   bus    : keypad_input_unit_if.master (key inputs, operand/status outputs)
// All outputs are registered; a key is accepted on the rising edge of
// IN_key_down only.
module keypad_input_unit #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter logic [3:0]  KEY_EQ     = 4'hF
) (
  input  logic                   IN_clk,
  input  logic                   IN_rst,
  keypad_input_unit_if.master    bus
);

  localparam int unsigned OPW = 16;
  localparam logic [1:0]  FLAG_MAX   = 2'(MAX_DIGITS);
  localparam logic [3:0]  DIGIT_LAST = 4'd9;
  localparam logic [3:0]  OP_FIRST   = 4'hA;
  localparam logic [3:0]  OP_LAST    = 4'hE;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_FIRST  = 2'd1,
    S_OP     = 2'd2,
    S_SECOND = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   src_q, src_d;
  logic [OPW-1:0]   dst_q, dst_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       flag_q, flag_d;
  logic             finish_q, finish_d;
  logic             key_prev_q;

  logic             accept_c;
  logic             is_digit_c;
  logic             is_op_c;
  logic             is_eq_c;
  logic             room_c;
  logic [OPW-1:0]   digit_c;
  logic [OPW-1:0]   src_acc_c;
  logic [OPW-1:0]   dst_acc_c;

  // Key classification and decimal accumulation (max 999, never overflows)
  assign accept_c   = bus.IN_key_down & ~key_prev_q;
  assign is_eq_c    = (bus.IN_key_code == KEY_EQ);
  assign is_digit_c = (bus.IN_key_code <= DIGIT_LAST) & ~is_eq_c;
  assign is_op_c    = (bus.IN_key_code >= OP_FIRST) & (bus.IN_key_code <= OP_LAST) & ~is_eq_c;
  assign room_c     = (flag_q < FLAG_MAX);
  assign digit_c    = {12'd0, bus.IN_key_code};
  assign src_acc_c  = OPW'(src_q * 16'd10) + digit_c;
  assign dst_acc_c  = OPW'(dst_q * 16'd10) + digit_c;

  // Next-state and output values; everything holds unless a key is accepted
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    op_d     = op_q;
    flag_d   = flag_q;
    finish_d = 1'b0;
    if (accept_c) begin
      unique case (state_q)
        S_WAIT: begin
          if (is_digit_c) begin
            state_d = S_FIRST;
            src_d   = digit_c;
            dst_d   = '0;
            op_d    = 4'h0;
            flag_d  = 2'd1;
          end else if (is_op_c) begin
            // Chaining: keep SRC so the core reuses its stored result
            state_d = S_OP;
            op_d    = bus.IN_key_code;
            dst_d   = '0;
            flag_d  = 2'd0;
          end
        end
        S_FIRST: begin
          if (is_digit_c) begin
            if (room_c) begin
              src_d  = src_acc_c;
              flag_d = flag_q + 2'd1;
            end
          end else if (is_op_c) begin
            state_d = S_OP;
            op_d    = bus.IN_key_code;
            flag_d  = 2'd0;
          end
        end
        S_OP: begin
          if (is_digit_c) begin
            state_d = S_SECOND;
            dst_d   = digit_c;
            flag_d  = 2'd1;
          end else if (is_op_c) begin
            op_d = bus.IN_key_code;
          end
        end
        S_SECOND: begin
          if (is_digit_c) begin
            if (room_c) begin
              dst_d  = dst_acc_c;
              flag_d = flag_q + 2'd1;
            end
          end else if (is_eq_c) begin
            state_d  = S_WAIT;
            flag_d   = 2'd0;
            finish_d = 1'b1;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state_q    <= S_WAIT;
      src_q      <= '0;
      dst_q      <= '0;
      op_q       <= 4'h0;
      flag_q     <= 2'd0;
      finish_q   <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      op_q       <= op_d;
      flag_q     <= flag_d;
      finish_q   <= finish_d;
      key_prev_q <= bus.IN_key_down;
    end
  end

  assign bus.OUT_SRCH   = src_q[15:8];
  assign bus.OUT_SRCL   = src_q[7:0];
  assign bus.OUT_DSTH   = dst_q[15:8];
  assign bus.OUT_DSTL   = dst_q[7:0];
  assign bus.OUT_ALU_OP = op_q;
  assign bus.OUT_finish = finish_q;
  assign bus.OUT_state  = state_q;
  assign bus.OUT_flag   = flag_q;

endmodule

// File: tb/tb_keypad_input_unit.sv
// Scoreboard bench for keypad_input_unit: every driven cycle queues the
// expected outputs for the following cycle; a negedge monitor pops and checks.
module tb_keypad_input_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  keypad_input_unit_if bus();

  keypad_input_unit dut (
    .IN_clk (clk),
    .IN_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [1:0]  st;
    logic [1:0]  fl;
    logic [15:0] src;
    logic [15:0] dst;
    logic [3:0]  op;
    logic        fin;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
    else
      n_pass++;
  endtask

  task automatic push(input logic [1:0] st, input logic [1:0] fl, input logic [15:0] src,
                      input logic [15:0] dst, input logic [3:0] op, input logic fin);
    exp_t e;
    e.due = cyc + 1;
    e.st = st; e.fl = fl; e.src = src; e.dst = dst; e.op = op; e.fin = fin;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      check("state",  16'(bus.OUT_state),  16'(mon_e.st));
      check("flag",   16'(bus.OUT_flag),   16'(mon_e.fl));
      check("src",    {bus.OUT_SRCH, bus.OUT_SRCL}, mon_e.src);
      check("dst",    {bus.OUT_DSTH, bus.OUT_DSTL}, mon_e.dst);
      check("alu_op", 16'(bus.OUT_ALU_OP), 16'(mon_e.op));
      check("finish", 16'(bus.OUT_finish), 16'(mon_e.fin));
    end
  end

  // Press a key for 'hold' cycles then release one cycle; the expected
  // values apply from the edge after the press, finish only on that first cycle.
  task automatic press(input logic [3:0] code, input int hold, input logic [1:0] st,
                       input logic [1:0] fl, input logic [15:0] src, input logic [15:0] dst,
                       input logic [3:0] op, input logic fin);
    @(negedge clk);
    bus.IN_key_down = 1'b1;
    bus.IN_key_code = code;
    push(st, fl, src, dst, op, fin);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      push(st, fl, src, dst, op, 1'b0);
    end
    @(negedge clk);
    bus.IN_key_down = 1'b0;
    bus.IN_key_code = 4'h0;
    push(st, fl, src, dst, op, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.IN_key_down = 1'b0;
    push(2'd0, 2'd0, 16'd0, 16'd0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push(2'd0, 2'd0, 16'd0, 16'd0, 4'h0, 1'b0);
  endtask

  initial begin
    bus.IN_key_down = 1'b0;
    bus.IN_key_code = 4'h0;

    // Basic 12 A 34 =
    do_reset();
    press(4'd1, 5, 2'd1, 2'd1, 16'd1,  16'd0,  4'h0, 1'b0);
    press(4'd2, 5, 2'd1, 2'd2, 16'd12, 16'd0,  4'h0, 1'b0);
    press(4'hA, 5, 2'd2, 2'd0, 16'd12, 16'd0,  4'hA, 1'b0);
    press(4'd3, 5, 2'd3, 2'd1, 16'd12, 16'd3,  4'hA, 1'b0);
    press(4'd4, 5, 2'd3, 2'd2, 16'd12, 16'd34, 4'hA, 1'b0);
    press(4'hF, 5, 2'd0, 2'd0, 16'd12, 16'd34, 4'hA, 1'b1);

    // Digit limit: fourth digit ignored
    do_reset();
    press(4'd1, 2, 2'd1, 2'd1, 16'd1,   16'd0, 4'h0, 1'b0);
    press(4'd2, 2, 2'd1, 2'd2, 16'd12,  16'd0, 4'h0, 1'b0);
    press(4'd3, 2, 2'd1, 2'd3, 16'd123, 16'd0, 4'h0, 1'b0);
    press(4'd4, 2, 2'd1, 2'd3, 16'd123, 16'd0, 4'h0, 1'b0);

    // Long hold: exactly one acceptance
    do_reset();
    press(4'd7, 20, 2'd1, 2'd1, 16'd7, 16'd0, 4'h0, 1'b0);

    // Operator replace, '=' ignored in S1/S2
    do_reset();
    press(4'd5, 2, 2'd1, 2'd1, 16'd5, 16'd0, 4'h0, 1'b0);
    press(4'hF, 2, 2'd1, 2'd1, 16'd5, 16'd0, 4'h0, 1'b0);
    press(4'hA, 2, 2'd2, 2'd0, 16'd5, 16'd0, 4'hA, 1'b0);
    press(4'hF, 2, 2'd2, 2'd0, 16'd5, 16'd0, 4'hA, 1'b0);
    press(4'hB, 2, 2'd2, 2'd0, 16'd5, 16'd0, 4'hB, 1'b0);
    press(4'd7, 2, 2'd3, 2'd1, 16'd5, 16'd7, 4'hB, 1'b0);
    press(4'hF, 2, 2'd0, 2'd0, 16'd5, 16'd7, 4'hB, 1'b1);

    // Chaining: operator straight from S0 keeps SRC, clears DST
    do_reset();
    press(4'd1, 2, 2'd1, 2'd1, 16'd1, 16'd0, 4'h0, 1'b0);
    press(4'hA, 2, 2'd2, 2'd0, 16'd1, 16'd0, 4'hA, 1'b0);
    press(4'd2, 2, 2'd3, 2'd1, 16'd1, 16'd2, 4'hA, 1'b0);
    press(4'hF, 2, 2'd0, 2'd0, 16'd1, 16'd2, 4'hA, 1'b1);
    press(4'hB, 2, 2'd2, 2'd0, 16'd1, 16'd0, 4'hB, 1'b0);
    press(4'd3, 2, 2'd3, 2'd1, 16'd1, 16'd3, 4'hB, 1'b0);
    press(4'hF, 2, 2'd0, 2'd0, 16'd1, 16'd3, 4'hB, 1'b1);

    // Reset mid-entry with a key edge in the same cycle
    do_reset();
    press(4'd4, 2, 2'd1, 2'd1, 16'd4, 16'd0,  4'h0, 1'b0);
    press(4'hA, 2, 2'd2, 2'd0, 16'd4, 16'd0,  4'hA, 1'b0);
    press(4'd4, 2, 2'd3, 2'd1, 16'd4, 16'd4,  4'hA, 1'b0);
    press(4'd5, 2, 2'd3, 2'd2, 16'd4, 16'd45, 4'hA, 1'b0);
    press(4'hC, 2, 2'd3, 2'd2, 16'd4, 16'd45, 4'hA, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.IN_key_down = 1'b1;
    bus.IN_key_code = 4'd7;
    push(2'd0, 2'd0, 16'd0, 16'd0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.IN_key_down = 1'b0;
    bus.IN_key_code = 4'h0;
    push(2'd0, 2'd0, 16'd0, 16'd0, 4'h0, 1'b0);
    press(4'd9, 2, 2'd1, 2'd1, 16'd9, 16'd0, 4'h0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("drain", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
